// File: rtl/palette_arbiter.sv
// Round-robin arbiter in front of the shared palette lookup, with a two-stage
// pipeline that returns each result tagged with its requester ID.
module palette_arbiter #(
    parameter int unsigned N_REQ           = 4,
    parameter bit          HI_PRIO_0       = 1'b0,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'h0,
    localparam int unsigned IDW            = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [4*N_REQ-1:0]   req_index_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic                 stall_i,
    output logic [3:0]           pal_index_o,
    input  logic [3:0]           pal_red_i,
    input  logic [3:0]           pal_green_i,
    input  logic [3:0]           pal_blue_i,
    output logic                 rsp_valid_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [11:0]          rsp_rgb_o,
    output logic                 rsp_transparent_o
);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           s1_valid_q, s1_valid_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [3:0]     pal_index_q, pal_index_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [11:0]    rsp_rgb_q, rsp_rgb_d;
    logic           rsp_transparent_q, rsp_transparent_d;

    logic           found;
    logic           accept;
    logic [IDW-1:0] winner;
    logic [3:0]     win_index;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [IDW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (HI_PRIO_0 && req_valid_i[0]) begin
            found  = 1'b1;
            winner = '0;
        end
    end

    assign accept = found & ~stall_i & ~reset_i;

    always_comb begin
        req_ready_o = '0;
        win_index   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (winner == IDW'(i)) begin
                req_ready_o[i] = accept;
                win_index      = req_index_i[4*i +: 4];
            end
        end
    end

    always_comb begin
        rr_ptr_d          = accept ? winner : rr_ptr_q;
        s1_valid_d        = stall_i ? s1_valid_q : accept;
        s1_id_d           = accept ? winner : s1_id_q;
        pal_index_d       = accept ? win_index : pal_index_q;
        rsp_valid_d       = ~stall_i & s1_valid_q;
        rsp_id_d          = rsp_id_q;
        rsp_rgb_d         = rsp_rgb_q;
        rsp_transparent_d = rsp_transparent_q;
        if (!stall_i && s1_valid_q) begin
            rsp_id_d          = s1_id_q;
            rsp_rgb_d         = {pal_red_i, pal_green_i, pal_blue_i};
            rsp_transparent_d = (pal_index_q == TRANSPARENT_IDX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q          <= IDW'(N_REQ - 1);
            s1_valid_q        <= 1'b0;
            s1_id_q           <= '0;
            pal_index_q       <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_rgb_q         <= '0;
            rsp_transparent_q <= 1'b0;
        end else begin
            rr_ptr_q          <= rr_ptr_d;
            s1_valid_q        <= s1_valid_d;
            s1_id_q           <= s1_id_d;
            pal_index_q       <= pal_index_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_id_q          <= rsp_id_d;
            rsp_rgb_q         <= rsp_rgb_d;
            rsp_transparent_q <= rsp_transparent_d;
        end
    end

    assign pal_index_o       = pal_index_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_id_o          = rsp_id_q;
    assign rsp_rgb_o         = rsp_rgb_q;
    assign rsp_transparent_o = rsp_transparent_q;

endmodule

// File: doc/palette_arbiter.md
# palette_arbiter

Round-robin arbiter and 2-stage pipeline that shares the single 16-entry, 4-bit-index palette lookup among several pixel requesters (background, fruit sprites, blade trail, score overlay). It grants one request per cycle, drives the palette index from a register, captures the palette's 12-bit RGB result and returns it tagged with the requester ID and a transparency flag. It sits between the sprite/background fetch logic and the VGA pixel mux.

## Interface
- N_REQ, 4, number of requesters (2..8); ID width IDW = $clog2(N_REQ)
- HI_PRIO_0, 0, when 1 requester 0 wins whenever valid; others round-robin
- TRANSPARENT_IDX, 4'h0, palette index reported as transparent (chroma key)

- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_index  in  4*N_REQ  per-requester palette index; requester i at [4i+3:4i]
- req_ready  out  N_REQ  one-hot grant; combinational
- stall  in  1  freeze pipeline, accept nothing
- pal_index  out  4  index to palette lookup; registered
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  IDW  requester that issued the result
- rsp_rgb  out  12  {red, green, blue}
- rsp_transparent  out  1  result index equalled TRANSPARENT_IDX

## Operation
- Handshake: request i accepted in cycle T iff req_valid[i] & req_ready[i]. Requester holds req_valid/req_index until accepted.
- req_ready = grant & ~stall & ~Reset; at most one bit set; never high for a requester whose req_valid is low.
- Arbitration: rr_ptr holds last granted ID. Search order rr_ptr+1, rr_ptr+2, … modulo N_REQ (wraps N_REQ-1 → 0); first valid wins. rr_ptr updates to winner only on accepted grant. HI_PRIO_0=1: req_valid[0] overrides search; rr_ptr still updates to 0 on that grant.
- Stage 1 (s1): on accept, s1_valid←1, s1_id←winner, pal_index←req_index of winner; no accept and no stall: s1_valid←0, pal_index holds value.
- Stage 2 (s2): when not stalled, rsp_valid←s1_valid; if s1_valid: rsp_id←s1_id, rsp_rgb←{pal_red,pal_green,pal_blue}, rsp_transparent←(pal_index==TRANSPARENT_IDX). rsp_id/rsp_rgb/rsp_transparent hold when rsp_valid←0.
- Stall: no grants; s1 registers and rr_ptr hold; rsp_valid←0 each stalled cycle; s2 data holds. On release the held s1 item advances normally; no item lost or duplicated.
- Reset: rr_ptr←N_REQ-1 (requester 0 first), s1_valid←0, pal_index←0, rsp_valid←0, rsp_id←0, rsp_rgb←0, rsp_transparent←0. Reset mid-stream discards in-flight items; no rsp_valid for them.

## Timing
- Latency: accept in cycle T → pal_index valid after edge T+1 → rsp_valid high for cycle after edge T+2 (2 cycles).
- Throughput: one result per cycle with continuous requests and stall low.
- Fairness: with all N_REQ valid continuously, each requester granted exactly once every N_REQ cycles (HI_PRIO_0=0).
- Simultaneous stall and valid: stall wins; req_ready all 0.
- Reset asserted same cycle as requests: req_ready all 0; no acceptance.
- Palette path is combinational between pal_index register and s2 register; no other combinational path from inputs to registered outputs.

## Test plan
- Reset then req_valid=4'b0001, index 4'h6 → req_ready=0001 same cycle, pal_index=6 at T+1, rsp_valid pulse at T+2 with rsp_id=0, rsp_rgb=12'hFD5, rsp_transparent=0.
- All 4 valid continuously, indices 1,2,3,4 → grants cycle 0,1,2,3,0…; rsp_id sequence 0,1,2,3 with rsp_rgb 00F,C77,119,EEE; rsp_valid high every cycle.
- Requester 2 only, index 4'h0 → rsp_rgb=12'h95B, rsp_transparent=1, rsp_id=2.
- Continuous requests, stall high 3 cycles mid-stream → req_ready=0 and rsp_valid=0 during stall; after release, results resume in order with no gap-filling duplicates or drops.
- HI_PRIO_0=1, all valid → requester 0 granted every cycle; drop req_valid[0] → grants rotate 1,2,3.
- Reset asserted with items in s1 and s2 → next cycle rsp_valid=0, pal_index=0, rsp_rgb=0; first post-reset grant goes to lowest valid ID.
